// File: rtl/repeated_subtract_divider.sv
// Sequential unsigned divider that subtracts the latched divisor once per clock.
// Optional `DIV_ABORT_EN adds an abort input that cancels a running division.
module repeated_subtract_divider #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
`ifdef DIV_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]   state;
  logic [N-1:0] div_reg;
  logic [N:0]   sum;
  logic [N-1:0] diff;
  logic         carry;
  logic         abort_req;

  // Subtract-mode adder: carry-out set means remainder >= divisor.
  assign sum   = {1'b0, remainder} + {1'b0, ~div_reg} + (N+1)'(1);
  assign diff  = sum[N-1:0];
  assign carry = sum[N];

`ifdef DIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      div_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remainder <= dividend;
            if (divisor == '0) begin
              quotient    <= '1;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              div_reg     <= divisor;
              quotient    <= '0;
              div_by_zero <= 1'b0;
              state       <= SUB;
            end
          end
        end
        SUB: begin
          // Abort takes priority over both a subtraction and completion.
          if (abort_req) begin
            state <= IDLE;
          end else if (carry) begin
            remainder <= diff;
            quotient  <= quotient + N'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SUB);
  assign done = (state == DONE);

endmodule

// File: doc/repeated_subtract_divider.md
Name: repeated_subtract_divider

Overview:
- Sequential unsigned divider built on repeated subtraction; the inverse of the add-and-latch accumulator datapath.
- A remainder register is loaded with the dividend. The latched divisor is subtracted once per clock, through an adder in subtract mode (B inverted, carry-in 1), until the remainder drops below the divisor.
- A quotient counter increments on every successful subtraction.
- Sits beside the accumulator in the ALU and uses a start/busy/done handshake.

Parameters:
- N, 4, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- clr  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  N  unsigned dividend; sampled with start.
- divisor  input  N  unsigned divisor; sampled with start.
- busy  output  1  high while subtracting (SUB state).
- done  output  1  one-cycle pulse; results valid.
- quotient  output  N  quotient register.
- remainder  output  N  remainder register.
- div_by_zero  output  1  high with done when the sampled divisor was 0; held until the next accepted start.

Behaviour:
- Interface (already decided): one clock, clk; reset clr is asynchronous and active-high.
- Reset: clr high forces IDLE immediately, independent of clk. All outputs go to 0: busy, done, quotient, remainder, div_by_zero. The internal divisor register is also cleared.
- Reset mid-operation: the computation is abandoned and no done pulse is produced. After clr deasserts, the block waits in IDLE for a new start.
- States: IDLE, SUB, DONE. Two-bit encoding.
- IDLE, start=1, divisor≠0:
  - Latch the divisor.
  - Load remainder=dividend, quotient=0, div_by_zero=0.
  - Go to SUB.
- IDLE, start=1, divisor=0:
  - Load remainder=dividend, quotient=all ones, div_by_zero=1.
  - Go directly to DONE.
- IDLE, start=0: hold all registers.
- SUB: compute diff = remainder + ~div_reg + 1 over N bits, with carry-out c.
  - c=1 (remainder ≥ divisor): remainder←diff, quotient←quotient+1, stay in SUB.
  - c=0: registers unchanged, go to DONE.
- DONE: go to IDLE unconditionally on the next edge.
- Output decode: busy = (state==SUB); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Latency: with q = floor(dividend/divisor), done is high in the cycle after edge S+q+1, where S is the edge that sampled start. For divisor=0, done is high in the cycle directly after edge S.
- start is ignored in SUB and DONE. No queuing and no restart.
- quotient and remainder are working registers. They change during SUB and are valid from done until the next accepted start.
- Quotient cannot overflow when divisor ≥ 1, since q ≤ dividend ≤ 2^N−1. No wrap handling is required.
- dividend=0 or dividend<divisor: SUB lasts exactly one cycle; q=0, remainder=dividend.
- dividend and divisor are don't-care outside the IDLE sampling edge.

Optional Feature:
- Macro: DIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in SUB returns the block to IDLE on the next edge. No done pulse is produced.
  - quotient and remainder keep their partial values; div_by_zero stays 0.
  - abort is ignored in IDLE and DONE.
  - abort and the SUB→DONE transition on the same edge: abort wins.
- Undefined: no abort port; SUB always runs to DONE.

Test Plan (N=4):
- 13/4: start in IDLE with dividend=13, divisor=4 → busy for 4 cycles, then done for 1 cycle, 5 cycles after the start edge; quotient=3, remainder=1, div_by_zero=0.
- Dividend below divisor: dividend=3, divisor=5 → busy for 1 cycle, done 2 cycles after start; quotient=0, remainder=3.
- Maximum-length run: dividend=15, divisor=1 → busy for 16 cycles, done 17 cycles after start; quotient=15, remainder=0.
- Divide by zero: dividend=9, divisor=0 → no busy; done 1 cycle after start; quotient=15, remainder=9, div_by_zero=1.
- Reset and ignored start:
  - 15/1 started; pulse clr mid-SUB with no clock edge → all outputs 0 immediately; no done pulse; state is IDLE.
  - A second start issued while busy is ignored: results match the first operands.
- With DIV_ABORT_EN: start 15/1, assert abort in the 3rd busy cycle → busy falls on the next edge with no done; a following 13/4 request returns 3 r 1.
